// File: rtl/verinject_memn_injector.sv
// Memory fault injector: captures in-window injection indices into a bounded entry store
// and XOR-flips the matching bits on every read port until the word is rewritten.
module verinject_memn_injector #(
    parameter int          LEFT          = 0,
    parameter int          RIGHT         = 0,
    parameter int          ADDR_LEFT     = 0,
    parameter int          ADDR_RIGHT    = 0,
    parameter int          MEM_LEFT      = 0,
    parameter int          MEM_RIGHT     = 0,
    parameter int unsigned P_START       = 0,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned READ_PORTS    = 1,
    parameter int unsigned OVERFLOW_MODE = 0,
    localparam int unsigned W  = 32'((LEFT >= RIGHT) ? (LEFT - RIGHT + 1) : (RIGHT - LEFT + 1)),
    localparam int unsigned A  = 32'((ADDR_LEFT >= ADDR_RIGHT) ? (ADDR_LEFT - ADDR_RIGHT + 1)
                                                               : (ADDR_RIGHT - ADDR_LEFT + 1)),
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                verinject__injector_state,
    input  logic [READ_PORTS*W-1:0]    unmodified,
    input  logic [READ_PORTS*A-1:0]    read_address,
    output logic [READ_PORTS*W-1:0]    modified,
    input  logic                       do_write,
    input  logic [A-1:0]               write_address,
    output logic [CW-1:0]              fifo_count,
    output logic                       overflow
);

    localparam int unsigned MEM_START = 32'((MEM_LEFT <= MEM_RIGHT) ? MEM_LEFT : MEM_RIGHT);
    localparam int unsigned MEM_LEN   = 32'((MEM_LEFT <= MEM_RIGHT) ? (MEM_RIGHT - MEM_LEFT + 1)
                                                                    : (MEM_LEFT - MEM_RIGHT + 1));
    localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] IDX_START = 32'(P_START);
    localparam logic [31:0] IDX_END   = 32'(P_START + MEM_LEN * W);
    localparam logic [31:0] W32       = 32'(W);

    logic [31:0]     idx_r [FIFO_DEPTH];
    logic [31:0]     idx_n [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_r;
    logic [FIFO_DEPTH-1:0] valid_c;
    logic [FIFO_DEPTH-1:0] valid_n;
    logic [PW-1:0]   repl_ptr;
    logic [PW-1:0]   ptr_n;
    logic [CW-1:0]   count_n;
    logic            ovf_n;
    logic            accept;
    logic            dup;
    logic            found;
    logic [32:0]     wr_base;
    logic [W-1:0]    mask_d [READ_PORTS];
    logic [W-1:0]    mask_r [READ_PORTS];

    // {in_range, first global index of the word}; out-of-range addresses match nothing
    function automatic logic [32:0] word_base(input logic [A-1:0] addr);
        logic [31:0] a32;
        logic [31:0] k;
        a32 = 32'(addr);
        k   = a32 - 32'(MEM_START);
        return {(a32 >= 32'(MEM_START)) && (k < 32'(MEM_LEN)), 32'(P_START) + k * W32};
    endfunction

    function automatic logic in_word(input logic [32:0] wb, input logic [31:0] idx);
        return wb[32] && ((idx - wb[31:0]) < W32);
    endfunction

    function automatic logic [W-1:0] bit_mask(input logic [32:0] wb, input logic [31:0] idx);
        logic [W-1:0] m;
        for (int unsigned b = 0; b < W; b++) begin
            m[b] = wb[32] && (idx == wb[31:0] + 32'(b));
        end
        return m;
    endfunction

    // Entry update: write-clear first, then toggle / allocate / overflow on post-clear validity
    always_comb begin
        accept  = (verinject__injector_state >= IDX_START) && (verinject__injector_state < IDX_END);
        wr_base = word_base(write_address);
        idx_n   = idx_r;
        ptr_n   = repl_ptr;
        ovf_n   = overflow;
        dup     = 1'b0;
        found   = 1'b0;
        count_n = '0;
        for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
            valid_c[e] = valid_r[e] && !(do_write && in_word(wr_base, idx_r[e]));
        end
        valid_n = valid_c;
        if (accept) begin
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                if (valid_c[e] && (idx_r[e] == verinject__injector_state)) begin
                    valid_n[e] = 1'b0;
                    dup        = 1'b1;
                end
            end
            if (!dup) begin
                for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                    if (!found && !valid_c[e]) begin
                        idx_n[e]   = verinject__injector_state;
                        valid_n[e] = 1'b1;
                        found      = 1'b1;
                    end
                end
                if (!found) begin
                    ovf_n = 1'b1;
                    if (OVERFLOW_MODE == 1) begin
                        for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                            if (repl_ptr == PW'(e)) begin
                                idx_n[e]   = verinject__injector_state;
                                valid_n[e] = 1'b1;
                            end
                        end
                        ptr_n = (repl_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : repl_ptr + PW'(1);
                    end
                end
            end
        end
        for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
            count_n = count_n + CW'(valid_n[e]);
        end
    end

    // Per-port mask from pre-edge entries plus the injection presented this cycle
    always_comb begin
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            logic [32:0]  rd_base;
            logic [W-1:0] m;
            rd_base = word_base(read_address[p*A +: A]);
            m       = '0;
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                if (valid_r[e]) begin
                    m = m ^ bit_mask(rd_base, idx_r[e]);
                end
            end
            if (accept) begin
                m = m ^ bit_mask(rd_base, verinject__injector_state);
            end
            mask_d[p] = m;
        end
    end

    always_comb begin
        modified = unmodified;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            modified[p*W +: W] = unmodified[p*W +: W] ^ mask_r[p];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r    <= '0;
            repl_ptr   <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            for (int unsigned p = 0; p < READ_PORTS; p++) begin
                mask_r[p] <= '0;
            end
        end else begin
            valid_r    <= valid_n;
            repl_ptr   <= ptr_n;
            fifo_count <= count_n;
            overflow   <= ovf_n;
            for (int unsigned p = 0; p < READ_PORTS; p++) begin
                mask_r[p] <= mask_d[p];
            end
        end
    end

    // Index payload is qualified by valid_r, so it needs no reset
    always_ff @(posedge clock) begin
        for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
            idx_r[e] <= idx_n[e];
        end
    end

endmodule

// File: tb/tb_verinject_memn_injector.sv
// Scoreboard bench: a drop-mode and a replace-mode injector driven in lockstep,
// expected read data and status queued with each stimulus cycle.
module tb_verinject_memn_injector;

    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    typedef struct {
        int         id;
        logic       dut;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [1:0] cnt;
        logic       ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] state;
    logic [15:0] unmod;
    logic [7:0]  raddr;
    logic        do_write;
    logic [3:0]  waddr;
    logic [15:0] mod0;
    logic [15:0] mod1;
    logic [1:0]  cnt0;
    logic [1:0]  cnt1;
    logic        ovf0;
    logic        ovf1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    verinject_memn_injector #(
        .LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0), .MEM_LEFT(0), .MEM_RIGHT(15),
        .P_START(100), .FIFO_DEPTH(2), .READ_PORTS(2), .OVERFLOW_MODE(0)
    ) dut0 (
        .clock(clk), .reset(reset), .verinject__injector_state(state),
        .unmodified(unmod), .read_address(raddr), .modified(mod0),
        .do_write(do_write), .write_address(waddr), .fifo_count(cnt0), .overflow(ovf0)
    );

    verinject_memn_injector #(
        .LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0), .MEM_LEFT(0), .MEM_RIGHT(15),
        .P_START(100), .FIFO_DEPTH(2), .READ_PORTS(2), .OVERFLOW_MODE(1)
    ) dut1 (
        .clock(clk), .reset(reset), .verinject__injector_state(state),
        .unmodified(unmod), .read_address(raddr), .modified(mod1),
        .do_write(do_write), .write_address(waddr), .fifo_count(cnt1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, queue expectations (k* for drop mode, j* for replace mode), then compare
    task automatic step(input int id, input logic [31:0] st, input logic [3:0] ra0,
                        input logic [3:0] ra1, input logic wr, input logic [3:0] wa,
                        input logic rst, input logic [7:0] k0, input logic [7:0] k1,
                        input logic [7:0] j0, input logic [7:0] j1,
                        input logic [1:0] c, input logic o);
        logic [7:0] u0;
        logic [7:0] u1;
        exp_t       e;
        u0       = 8'($urandom);
        u1       = 8'($urandom);
        state    = st;
        raddr    = {ra1, ra0};
        unmod    = {u1, u0};
        do_write = wr;
        waddr    = wa;
        reset    = rst;
        e.id = id; e.dut = 1'b0; e.m0 = u0 ^ k0; e.m1 = u1 ^ k1; e.cnt = c; e.ovf = o;
        sb.push_back(e);
        e.dut = 1'b1; e.m0 = u0 ^ j0; e.m1 = u1 ^ j1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.dut) begin
                check_eq($sformatf("s%0d_d0_mod0", e.id), 32'(mod0[7:0]), 32'(e.m0));
                check_eq($sformatf("s%0d_d0_mod1", e.id), 32'(mod0[15:8]), 32'(e.m1));
                check_eq($sformatf("s%0d_d0_count", e.id), 32'(cnt0), 32'(e.cnt));
                check_eq($sformatf("s%0d_d0_overflow", e.id), 32'(ovf0), 32'(e.ovf));
            end else begin
                check_eq($sformatf("s%0d_d1_mod0", e.id), 32'(mod1[7:0]), 32'(e.m0));
                check_eq($sformatf("s%0d_d1_mod1", e.id), 32'(mod1[15:8]), 32'(e.m1));
                check_eq($sformatf("s%0d_d1_count", e.id), 32'(cnt1), 32'(e.cnt));
                check_eq($sformatf("s%0d_d1_overflow", e.id), 32'(ovf1), 32'(e.ovf));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        state    = IDLE;
        raddr    = '0;
        unmod    = '0;
        do_write = 1'b0;
        waddr    = '0;
        repeat (2) @(posedge clk);
        #1;
        //    id  state  a0 a1 wr wa rst  k0     k1     j0     j1     cnt ovf
        step( 0, IDLE,   0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        // basic flip: 110 -> word 1 bit 2
        step( 1, 110,    1, 2, 0, 0, 0, 8'h04, 8'h00, 8'h04, 8'h00, 1, 0);
        step( 2, IDLE,   1, 2, 0, 0, 0, 8'h04, 8'h00, 8'h04, 8'h00, 1, 0);
        step( 3, IDLE,   2, 1, 0, 0, 0, 8'h00, 8'h04, 8'h00, 8'h04, 1, 0);
        // write clear; same-cycle read still sees the pre-clear entry
        step( 4, IDLE,   1, 1, 1, 1, 0, 8'h04, 8'h04, 8'h04, 8'h04, 0, 0);
        step( 5, IDLE,   1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        step( 6, 110,    3, 3, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        // write to word 1 together with injection 111: old entry cleared, new one kept
        step( 7, 111,    1, 0, 1, 1, 0, 8'h0C, 8'h00, 8'h0C, 8'h00, 1, 0);
        step( 8, IDLE,   1, 1, 0, 0, 0, 8'h08, 8'h08, 8'h08, 8'h08, 1, 0);
        step( 9, IDLE,   0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        // duplicate toggle: 120 -> word 2 bit 4
        step(10, 120,    2, 5, 0, 0, 0, 8'h10, 8'h00, 8'h10, 8'h00, 1, 0);
        step(11, IDLE,   2, 2, 0, 0, 0, 8'h10, 8'h10, 8'h10, 8'h10, 1, 0);
        step(12, 120,    2, 3, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        step(13, IDLE,   2, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        // overflow: 100, 108, 116 into a two-entry store
        step(14, 100,    0, 1, 0, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 1, 0);
        step(15, 108,    0, 1, 0, 0, 0, 8'h01, 8'h01, 8'h01, 8'h01, 2, 0);
        step(16, 116,    2, 0, 0, 0, 0, 8'h01, 8'h01, 8'h01, 8'h01, 2, 1);
        step(17, IDLE,   2, 0, 0, 0, 0, 8'h00, 8'h01, 8'h01, 8'h00, 2, 1);
        step(18, IDLE,   1, 0, 0, 0, 0, 8'h01, 8'h01, 8'h01, 8'h00, 2, 1);
        step(19, IDLE,   0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        // window edges: 99 and 228 outside, 227 is the last bit of word 15
        step(20, 99,     0, 15, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        step(21, 228,    15, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        step(22, 227,    15, 0, 0, 0, 0, 8'h80, 8'h00, 8'h80, 8'h00, 1, 0);
        step(23, 104,    0, 15, 0, 0, 0, 8'h10, 8'h80, 8'h10, 8'h80, 2, 0);
        step(24, 105,    0, 15, 0, 0, 0, 8'h30, 8'h80, 8'h30, 8'h80, 2, 1);
        // reset wins over a same-cycle injection
        step(25, 106,    0, 15, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        step(26, IDLE,   0, 15, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
